// File: rtl/debug_tx_serializer_pkg.sv
// Shared debug definitions: default debug word / UART byte widths and the
// serializer state encoding used by the debug unit.
package debug_tx_serializer_pkg;

    localparam int TAM_DATA_DEF = 32;
    localparam int TAM_BYTE_DEF = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        SEND      = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/debug_tx_serializer_word_fifo.sv
// Small synchronous word FIFO with a combinational head-of-queue output.
// DEPTH must be a power of two so the pointers wrap naturally.
module word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (PTR_W+1)'(1'b1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1'b1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/debug_tx_serializer.sv
// Buffers debug words and feeds them MSB byte first to a UART transmitter,
// one start pulse per byte, waiting for the transmitter's done tick.
module debug_tx_serializer
    import debug_tx_serializer_pkg::*;
#(
    parameter int TAM_DATA   = TAM_DATA_DEF,
    parameter int TAM_BYTE   = TAM_BYTE_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_enable_enviada_data,
    input  logic [TAM_DATA-1:0]           i_data_enviada,
    input  logic                          i_tx_done,
    output logic                          o_tx_start,
    output logic [TAM_BYTE-1:0]           o_tx_data,
    output logic                          o_busy,
    output logic                          o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int NBYTES = TAM_DATA / TAM_BYTE;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int FC_W   = $clog2(FIFO_DEPTH) + 1;

    tx_state_e            state_q, state_d;
    logic [TAM_DATA-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic                 tx_start_q, tx_start_d;
    logic [TAM_BYTE-1:0]  tx_data_q, tx_data_d;
    logic                 overflow_q, overflow_d;

    logic [TAM_DATA-1:0]  fifo_dout;
    logic [FC_W-1:0]      fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic [TAM_DATA-1:0]  shift_nx;
    logic                 last_byte;

    // Fullness is judged on the registered count, so a same-cycle pop does not save the word
    assign fifo_push  = i_enable_enviada_data && !fifo_full;
    assign overflow_d = overflow_q || (i_enable_enviada_data && fifo_full);
    assign shift_nx   = shift_q << TAM_BYTE;
    assign last_byte  = (byte_cnt_q == CNT_W'(NBYTES - 1));

    word_fifo #(
        .WIDTH (TAM_DATA),
        .DEPTH (FIFO_DEPTH)
    ) u_word_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     (i_data_enviada),
        .dout    (fifo_dout),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Serializer next-state; start/data are computed one edge early so the outputs are flops
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        fifo_pop   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                fifo_pop   = 1'b1;
                shift_d    = fifo_dout;
                byte_cnt_d = '0;
                tx_start_d = 1'b1;
                tx_data_d  = fifo_dout[TAM_DATA-1 -: TAM_BYTE];
                state_d    = SEND;
            end
            SEND: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (i_tx_done) begin
                    shift_d    = shift_nx;
                    byte_cnt_d = byte_cnt_q + CNT_W'(1'b1);
                    if (last_byte) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = SEND;
                        tx_start_d = 1'b1;
                        tx_data_d  = shift_nx[TAM_DATA-1 -: TAM_BYTE];
                    end
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Serializer state registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_tx_start   = tx_start_q;
    assign o_tx_data    = tx_data_q;
    assign o_overflow   = overflow_q;
    assign o_fifo_count = fifo_count;
    assign o_busy       = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_debug_tx_serializer.sv
// Self-checking bench: directed scenarios plus random traffic, compared each
// cycle against a word/byte-level timing model of the serializer.
module tb_debug_tx_serializer;

    localparam int TD   = 32;
    localparam int TB   = 8;
    localparam int DEP  = 4;
    localparam int NB   = TD / TB;
    localparam int FCW  = $clog2(DEP) + 1;
    localparam int NEVER = 32'h3fff_ffff;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            stb = 1'b0;
    logic [TD-1:0]   din = '0;
    logic            done = 1'b0;
    logic            o_tx_start;
    logic [TB-1:0]   o_tx_data;
    logic            o_busy;
    logic            o_overflow;
    logic [FCW-1:0]  o_fifo_count;

    always #5 clk = ~clk;

    debug_tx_serializer #(
        .TAM_DATA   (TD),
        .TAM_BYTE   (TB),
        .FIFO_DEPTH (DEP)
    ) dut (
        .i_clk                 (clk),
        .i_reset               (rst),
        .i_enable_enviada_data (stb),
        .i_data_enviada        (din),
        .i_tx_done             (done),
        .o_tx_start            (o_tx_start),
        .o_tx_data             (o_tx_data),
        .o_busy                (o_busy),
        .o_overflow            (o_overflow),
        .o_fifo_count          (o_fifo_count)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: word queue plus the cycle numbers at which the spec's timing rules put events
    logic [TD-1:0] q[$];
    logic [TD-1:0] cur      = '0;
    logic [TB-1:0] exp_data = '0;
    logic          exp_ovf  = 1'b0;
    int            free_at  = 0;
    int            pop_c    = -1;
    int            start_c  = -1;
    int            done_c   = -1;
    int            k        = 0;
    int            tx_lat   = 10;
    bit            cmp_en   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: check outputs of this cycle, drive inputs, advance the model
    task automatic step(input bit r, input bit s, input logic [TD-1:0] d, input bit stray);
        int size0;
        bit idle_c;
        bit exp_start;
        bit drv_done;
        size0     = q.size();
        idle_c    = (free_at <= cyc);
        exp_start = (cyc == start_c);
        if (exp_start) begin
            exp_data = cur[(TD-1-TB*k) -: TB];
        end
        if (cmp_en) begin
            check_eq("tx_start",   32'(o_tx_start),   32'(exp_start));
            check_eq("tx_data",    32'(o_tx_data),    32'(exp_data));
            check_eq("fifo_count", 32'(o_fifo_count), 32'(size0));
            check_eq("busy",       32'(o_busy),       32'(!idle_c || size0 != 0));
            check_eq("overflow",   32'(o_overflow),   32'(exp_ovf));
        end
        // stray ticks are only issued outside the window where a real done is awaited
        drv_done = (cyc == done_c) || (stray && !(cyc > start_c && cyc < done_c));
        rst  = r;
        stb  = s;
        din  = d;
        done = drv_done;
        if (r) begin
            q.delete();
            free_at  = cyc + 1;
            pop_c    = -1;
            start_c  = -1;
            done_c   = -1;
            k        = 0;
            exp_data = '0;
            exp_ovf  = 1'b0;
        end else begin
            if (idle_c && size0 > 0) begin
                pop_c   = cyc + 1;
                start_c = cyc + 2;
                free_at = NEVER;
                k       = 0;
            end
            if (cyc == pop_c) begin
                cur = q.pop_front();
            end
            if (exp_start) begin
                done_c = cyc + tx_lat;
            end
            if (cyc == done_c) begin
                k++;
                if (k < NB) begin
                    start_c = cyc + 1;
                end else begin
                    free_at = cyc + 1;
                end
            end
            if (s) begin
                if (size0 < DEP) begin
                    q.push_back(d);
                end else begin
                    exp_ovf = 1'b1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        cmp_en = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 32'hdead_0000, 1'b0);

        // single word, done 10 cycles after each start
        tx_lat = 10;
        step(1'b0, 1'b1, 32'h1234_5678, 1'b0);
        repeat (60) step(1'b0, 1'b0, '0, 1'b0);

        // back-to-back strobes
        step(1'b0, 1'b1, 32'haabb_ccdd, 1'b0);
        step(1'b0, 1'b1, 32'h0102_0304, 1'b0);
        repeat (100) step(1'b0, 1'b0, '0, 1'b0);

        // overflow: long done latency, six strobes into a depth-4 buffer
        tx_lat = 40;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, TD'(i), 1'b0);
        repeat (850) step(1'b0, 1'b0, '0, 1'b0);

        // stray done ticks in IDLE and during sending
        tx_lat = 10;
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 32'h5a5a_a5a5, 1'b1);
        repeat (60) step(1'b0, 1'b0, '0, ($urandom_range(0, 2) == 0));

        // reset after the second byte with one word still buffered
        step(1'b0, 1'b1, 32'hcafe_babe, 1'b0);
        step(1'b0, 1'b1, 32'hdead_beef, 1'b0);
        repeat (24) step(1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 32'h9999_9999, 1'b0);
        step(1'b0, 1'b1, 32'h1122_3344, 1'b0);
        repeat (60) step(1'b0, 1'b0, '0, 1'b0);

        // strobe coinciding with the LOAD of a queued word
        step(1'b0, 1'b1, 32'h0a0b_0c0d, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 32'h0e0f_1011, 1'b0);
        repeat (100) step(1'b0, 1'b0, '0, 1'b0);

        // random traffic with random done latency, stray ticks and rare resets
        for (int i = 0; i < 1500; i++) begin
            tx_lat = $urandom_range(1, 6);
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 5) == 0),
                 TD'($urandom), ($urandom_range(0, 15) == 0));
        end
        tx_lat = 3;
        repeat (200) step(1'b0, 1'b0, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
